dm_sync_bytelane: RTL

Parametrised data memory for the MIPS CPU data path: successor to the single-cycle word/rotated-store data memory. Adds byte and halfword loads/stores with sign/zero extension, alignment and range checking, and a configurable access latency behind a Req/Ready handshake. It serves the MEM stage, which stalls on Busy.

---
 rtl/dm_sync_bytelane_if.sv | 25 ++
 rtl/dm_sync_bytelane.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sync_bytelane_if.sv
// Request/response bundle between the MEM stage and dm_sync_bytelane.
// The master issues Req with its operands; the slave answers with Busy/Ready/RD/Err.
interface dm_sync_bytelane_if;
  logic        Req;
  logic        We;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] PC;
  logic        Busy;
  logic        Ready;
  logic [31:0] RD;
  logic        Err;
  logic [1:0]  ErrCode;

  modport master (
    output Req, We, Op, A, WD, PC,
    input  Busy, Ready, RD, Err, ErrCode
  );

  modport slave (
    input  Req, We, Op, A, WD, PC,
    output Busy, Ready, RD, Err, ErrCode
  );
endinterface

// File: rtl/dm_sync_bytelane.sv
// Byte-lane data memory with configurable latency behind a Req/Ready handshake.
// Supports word/half/byte loads and stores, rotated stores, and alignment/range checks.
module dm_sync_bytelane #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LAT    = 2,
  parameter bit          ROT_EN = 1'b1
) (
  input logic               CLK,
  input logic               Reset,
  dm_sync_bytelane_if.slave bus
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

  localparam logic [2:0] OP_WORD = 3'b000;
  localparam logic [2:0] OP_HU   = 3'b001;
  localparam logic [2:0] OP_HS   = 3'b010;
  localparam logic [2:0] OP_BU   = 3'b011;
  localparam logic [2:0] OP_BS   = 3'b100;
  localparam logic [2:0] OP_ROT  = 3'b101;
  localparam logic [2:0] OP_RSV0 = 3'b110;
  localparam logic [2:0] OP_RSV1 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              accept_s;
  logic              access_s;
  logic [3:0]        cnt_r;

  logic              we_r;
  logic [2:0]        op_r;
  logic [31:0]       a_r;
  logic [31:0]       wd_r;
  logic [31:0]       pc_r;

  logic              busy_r;
  logic              ready_r;
  logic              err_r;
  logic [1:0]        err_code_r;
  logic [31:0]       rd_r;

  logic [31:0]       mem_r [DEPTH];

  logic [ADDR_W-1:0] index_s;
  logic [31:0]       old_word_s;
  logic [31:0]       merged_s;
  logic [31:0]       load_s;
  logic [1:0]        err_code_s;
  logic              err_s;

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic m;
    case (op)
      OP_HU, OP_HS: m = lane[0];
      OP_WORD:      m = (lane != 2'b00);
      OP_ROT:       m = ROT_EN ? 1'b0 : (lane != 2'b00);
      default:      m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic out_of_range(input logic [2:0] op, input logic [31:0] a);
    return ((a >> (ADDR_W + 2)) != 32'd0) || (op == OP_RSV0) || (op == OP_RSV1);
  endfunction

  // Rotation reads a 32-bit window out of the doubled word: ror(wd, s) = {wd,wd}[s +: 32].
  function automatic logic [31:0] merge_store(input logic [2:0] op, input logic [1:0] lane,
                                              input logic [31:0] wd, input logic [31:0] old);
    logic [31:0] w;
    logic [63:0] dbl;
    dbl = {wd, wd};
    w   = old;
    case (op)
      OP_WORD: w = wd;
      OP_HU, OP_HS: begin
        if (lane[1]) begin
          w = {wd[15:0], old[15:0]};
        end else begin
          w = {old[31:16], wd[15:0]};
        end
      end
      OP_BU, OP_BS: w[{lane, 3'b000} +: 8] = wd[7:0];
      OP_ROT: begin
        if (ROT_EN) begin
          w = dbl[{1'b0, lane, 3'b000} +: 32];
        end else begin
          w = wd;
        end
      end
      default: w = old;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extract_load(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = lane[1] ? w[31:16] : w[15:0];
    b = w[{lane, 3'b000} +: 8];
    case (op)
      OP_HU:   r = {16'h0000, h};
      OP_HS:   r = {{16{h[15]}}, h};
      OP_BU:   r = {24'h000000, b};
      OP_BS:   r = {{24{b[7]}}, b};
      default: r = w;
    endcase
    return r;
  endfunction

  assign index_s    = a_r[ADDR_W+1:2];
  assign old_word_s = mem_r[index_s];
  assign err_code_s = {out_of_range(op_r, a_r), misaligned(op_r, a_r[1:0])};
  assign err_s      = |err_code_s;
  assign merged_s   = merge_store(op_r, a_r[1:0], wd_r, old_word_s);
  assign load_s     = extract_load(op_r, a_r[1:0], old_word_s);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: accept in IDLE or RESP, access once the countdown has expired.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    access_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.Req) begin
          accept_s = 1'b1;
          state_s  = ST_WAIT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          access_s = 1'b1;
          state_s  = ST_RESP;
        end else begin
          state_s  = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.Req) begin
          accept_s = 1'b1;
          state_s  = ST_WAIT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Request capture and latency countdown.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_r <= 4'd0;
      we_r  <= 1'b0;
      op_r  <= 3'b000;
      a_r   <= 32'h0000_0000;
      wd_r  <= 32'h0000_0000;
      pc_r  <= 32'h0000_0000;
    end else if (accept_s) begin
      cnt_r <= CNT_INIT;
      we_r  <= bus.We;
      op_r  <= bus.Op;
      a_r   <= bus.A;
      wd_r  <= bus.WD;
      pc_r  <= bus.PC;
    end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Response registers; RD/Err/ErrCode only change at an access edge.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      busy_r     <= 1'b0;
      ready_r    <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 2'b00;
      rd_r       <= 32'h0000_0000;
    end else begin
      busy_r  <= (state_s == ST_WAIT);
      ready_r <= access_s;
      if (access_s) begin
        err_r      <= err_s;
        err_code_r <= err_code_s;
        rd_r       <= (err_s || we_r) ? 32'h0000_0000 : load_s;
      end else begin
        err_r      <= err_r;
        err_code_r <= err_code_r;
        rd_r       <= rd_r;
      end
    end
  end

  // Storage array; reset wipes every word, rejected accesses never write.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (access_s && we_r && !err_s) begin
      mem_r[index_s] <= merged_s;
    end else begin
      mem_r[index_s] <= mem_r[index_s];
    end
  end

  // Store trace for the CPU simulation log.
  always_ff @(posedge CLK) begin
    if (!Reset && access_s && we_r && !err_s) begin
      $display("@%h: *%h <= %h", pc_r, {a_r[31:2], 2'b00}, merged_s);
    end
  end

  assign bus.Busy    = busy_r;
  assign bus.Ready   = ready_r;
  assign bus.RD      = rd_r;
  assign bus.Err     = err_r;
  assign bus.ErrCode = err_code_r;

endmodule
